// File: rtl/cut_bist_pkg.sv
// Shared FSM encoding, LFSR taps and MISR polynomial for the CUT BIST controller.
package cut_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_COMPARE,
        ST_DONE
    } bist_state_t;

    // x^36 + x^11 + 1: feedback taken from bits 35 and 10 of the shifting register
    localparam int LFSR_TAP_HI = 35;
    localparam int LFSR_TAP_LO = 10;

    localparam logic [15:0] MISR_POLY = 16'h1021;

endpackage

// File: rtl/cut_bist_misr.sv
// Multiple-input signature register: shifts left with polynomial feedback and folds in the response.
module cut_bist_misr
    import cut_bist_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter int               RSP_W = 7,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [RSP_W-1:0] i_rsp,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_next;

    always_comb begin
        w_next = (r_sig << 1) ^ (r_sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(i_rsp);
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= w_next;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/cut_bist_ctrl.sv
// BIST controller: LFSR pattern source, MISR response compactor and golden-signature check.
// Optional watchdog abort enabled by defining BIST_TIMEOUT_EN (adds the err output).
module cut_bist_ctrl
    import cut_bist_pkg::*;
#(
    parameter int               PAT_W     = 36,
    parameter int               RSP_W     = 7,
    parameter int               SIG_W     = 16,
    parameter int               NUM_PAT   = 1024,
    parameter logic [PAT_W-1:0] LFSR_SEED = PAT_W'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIG_W-1:0] golden_sig,
    output logic             busy,
    output logic             pat_valid,
    output logic [PAT_W-1:0] pat_out,
    input  logic             rsp_valid,
    input  logic [RSP_W-1:0] rsp_in,
    output logic [SIG_W-1:0] signature,
    output logic             done,
    output logic             pass
`ifdef BIST_TIMEOUT_EN
    ,
    output logic             err
`endif
);

    // An all-zero seed would lock the LFSR, so it is replaced by all-ones
    localparam logic [PAT_W-1:0] SEED     = (LFSR_SEED == '0) ? '1 : LFSR_SEED;
    localparam logic [15:0]      LAST_CNT = 16'(NUM_PAT - 1);

    bist_state_t      r_state;
    bist_state_t      w_next_state;
    logic [PAT_W-1:0] r_lfsr;
    logic [15:0]      r_cnt;
    logic             r_pass;
    logic             w_start;
    logic             w_accept;
    logic             w_last;
    logic             w_timeout;

    assign w_start  = (r_state == ST_IDLE) && start;
    assign w_accept = (r_state == ST_DRIVE) && rsp_valid;
    assign w_last   = w_accept && (r_cnt == LAST_CNT);

`ifdef BIST_TIMEOUT_EN
    logic [3:0] r_wdog;
    logic       r_err;

    // The 15th consecutive idle DRIVE cycle is the one that sees the count at 14
    assign w_timeout = (r_state == ST_DRIVE) && !rsp_valid && (r_wdog == 4'd14);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_start || w_accept) begin
                r_wdog <= '0;
            end else if (r_state == ST_DRIVE) begin
                r_wdog <= r_wdog + 4'd1;
            end
            if (w_start) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        pat_valid    = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                pat_valid = 1'b1;
                if (w_last) begin
                    w_next_state = ST_COMPARE;
                end else if (w_timeout) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_COMPARE: begin
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= '0;
            r_cnt  <= '0;
            r_pass <= 1'b0;
        end else begin
            if (w_start) begin
                r_lfsr <= SEED;
                r_cnt  <= '0;
                r_pass <= 1'b0;
            end else if (w_accept) begin
                r_lfsr <= {r_lfsr[PAT_W-2:0], r_lfsr[LFSR_TAP_HI] ^ r_lfsr[LFSR_TAP_LO]};
                r_cnt  <= r_cnt + 16'd1;
            end else if (r_state == ST_COMPARE) begin
                r_pass <= (signature == golden_sig);
            end
        end
    end

    cut_bist_misr #(
        .SIG_W (SIG_W),
        .RSP_W (RSP_W),
        .POLY  (SIG_W'(MISR_POLY))
    ) u_misr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_start),
        .i_en  (w_accept),
        .i_rsp (rsp_in),
        .o_sig (signature)
    );

    // Outside DRIVE the circuit inputs are parked at zero
    assign pat_out = pat_valid ? r_lfsr : '0;
    assign pass    = r_pass;

endmodule

// File: tb/tb_cut_bist_ctrl.sv
// Bench for cut_bist_ctrl: three instances (NUM_PAT 1, 2, 4) checked every cycle against a run-level model.
`timescale 1ns/1ps
module tb_cut_bist_ctrl;

    localparam int NI = 3;
    localparam int NF = 7;
`ifdef BIST_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    localparam int F_PAT  = 0;
    localparam int F_SIG  = 1;
    localparam int F_BUSY = 2;
    localparam int F_PV   = 3;
    localparam int F_DONE = 4;
    localparam int F_PASS = 5;
    localparam int F_ERR  = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start     [NI];
    logic        rsp_valid [NI];
    logic [6:0]  rsp_in    [NI];
    logic [15:0] golden    [NI];
    logic        busy      [NI];
    logic        pat_valid [NI];
    logic        done      [NI];
    logic        pass      [NI];
    logic        err       [NI];
    logic [35:0] pat_out   [NI];
    logic [15:0] signature [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        cut_bist_ctrl #(
            .NUM_PAT((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start[g]),
            .golden_sig (golden[g]),
            .busy       (busy[g]),
            .pat_valid  (pat_valid[g]),
            .pat_out    (pat_out[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_in     (rsp_in[g]),
            .signature  (signature[g]),
            .done       (done[g]),
            .pass       (pass[g])
`ifdef BIST_TIMEOUT_EN
            ,
            .err        (err[g])
`endif
        );
`ifndef BIST_TIMEOUT_EN
        assign err[g] = 1'b0;
`endif
    end

    // Run-level model: position in the run, accepted-pattern count, folded signature
    bit          m_run   [NI];
    int          m_tail  [NI];
    int          m_k     [NI];
    int          m_stall [NI];
    logic [15:0] m_sig   [NI];
    bit          m_pass  [NI];
    bit          m_err   [NI];

    bit          lit_en  [NI][NF];
    logic [63:0] lit_val [NI][NF];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int np(int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    function automatic logic [35:0] lfsr_nth(int k);
        logic [35:0] q;
        q = 36'h1;
        for (int s = 0; s < k; s++) q = {q[34:0], q[35] ^ q[10]};
        return q;
    endfunction

    function automatic logic [15:0] misr_next(logic [15:0] s, logic [6:0] r);
        return (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ {9'b0, r};
    endfunction

    function automatic string fname(int f);
        case (f)
            F_PAT:   return "pat_out";
            F_SIG:   return "signature";
            F_BUSY:  return "busy";
            F_PV:    return "pat_valid";
            F_DONE:  return "done";
            F_PASS:  return "pass";
            default: return "err";
        endcase
    endfunction

    function automatic logic [63:0] dut_f(int i, int f);
        case (f)
            F_PAT:   return {28'b0, pat_out[i]};
            F_SIG:   return {48'b0, signature[i]};
            F_BUSY:  return {63'b0, busy[i]};
            F_PV:    return {63'b0, pat_valid[i]};
            F_DONE:  return {63'b0, done[i]};
            F_PASS:  return {63'b0, pass[i]};
            default: return {63'b0, err[i]};
        endcase
    endfunction

    function automatic logic [63:0] model_f(int i, int f);
        case (f)
            F_PAT:   return m_run[i] ? {28'b0, lfsr_nth(m_k[i])} : 64'd0;
            F_SIG:   return {48'b0, m_sig[i]};
            F_BUSY:  return {63'b0, (m_run[i] || m_tail[i] != 0)};
            F_PV:    return {63'b0, m_run[i]};
            F_DONE:  return {63'b0, (m_tail[i] == 2)};
            F_PASS:  return {63'b0, m_pass[i]};
            default: return {63'b0, m_err[i]};
        endcase
    endfunction

    task automatic model_step(int i);
        if (rst) begin
            m_run[i] = 0; m_tail[i] = 0; m_k[i] = 0; m_stall[i] = 0;
            m_sig[i] = '0; m_pass[i] = 0; m_err[i] = 0;
        end else if (m_tail[i] == 1) begin
            m_pass[i] = (m_sig[i] == golden[i]);
            m_tail[i] = 2;
        end else if (m_tail[i] == 2) begin
            m_tail[i] = 0;
        end else if (m_run[i]) begin
            if (rsp_valid[i]) begin
                m_sig[i]   = misr_next(m_sig[i], rsp_in[i]);
                m_k[i]     = m_k[i] + 1;
                m_stall[i] = 0;
                if (m_k[i] == np(i)) begin
                    m_run[i]  = 0;
                    m_tail[i] = 1;
                end
            end else begin
                m_stall[i] = m_stall[i] + 1;
                if (TMO && m_stall[i] == 15) begin
                    m_run[i]  = 0;
                    m_tail[i] = 2;
                    m_err[i]  = 1;
                end
            end
        end else if (start[i]) begin
            m_run[i] = 1; m_k[i] = 0; m_stall[i] = 0;
            m_sig[i] = '0; m_pass[i] = 0; m_err[i] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_run[i] = 0; m_tail[i] = 0; m_k[i] = 0; m_stall[i] = 0;
            m_sig[i] = '0; m_pass[i] = 0; m_err[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            for (int f = 0; f < NF; f++) begin
                n_tests++;
                if (dut_f(i, f) !== model_f(i, f)) begin
                    n_fail++;
                    $display("FAIL model_%s inst%0d t=%0t: got %0h expected %0h",
                             fname(f), i, $time, dut_f(i, f), model_f(i, f));
                end
                if (lit_en[i][f]) begin
                    n_tests++;
                    if (dut_f(i, f) !== lit_val[i][f]) begin
                        n_fail++;
                        $display("FAIL lit_%s inst%0d t=%0t: got %0h expected %0h",
                                 fname(f), i, $time, dut_f(i, f), lit_val[i][f]);
                    end
                    n_tests++;
                    if (model_f(i, f) !== lit_val[i][f]) begin
                        n_fail++;
                        $display("FAIL pin_%s inst%0d t=%0t: model %0h expected %0h",
                                 fname(f), i, $time, model_f(i, f), lit_val[i][f]);
                    end
                end
            end
        end
        for (int i = 0; i < NI; i++) model_step(i);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            for (int f = 0; f < NF; f++) lit_en[i][f] = 1'b0;
    endtask

    task automatic lit(int i, int f, logic [63:0] v);
        lit_en[i][f]  = 1'b1;
        lit_val[i][f] = v;
    endtask

    task automatic finish_run(int i);
        repeat (3) tick();
    endtask

    task automatic run_basic(logic [15:0] g, bit exp_pass);
        golden[1] = g;
        start[1]  = 1'b1;
        tick();
        start[1] = 1'b0;
        lit(1, F_PV, 1); lit(1, F_PAT, 36'h1); lit(1, F_SIG, 0); lit(1, F_BUSY, 1);
        rsp_valid[1] = 1'b1; rsp_in[1] = 7'h55;
        tick();
        lit(1, F_PAT, 36'h2); lit(1, F_SIG, 16'h0055);
        rsp_in[1] = 7'h01;
        tick();
        lit(1, F_SIG, 16'h00AB); lit(1, F_PV, 0); lit(1, F_BUSY, 1); lit(1, F_DONE, 0);
        rsp_valid[1] = 1'b0;
        tick();
        lit(1, F_DONE, 1); lit(1, F_PASS, exp_pass);
        tick();
        lit(1, F_DONE, 0); lit(1, F_BUSY, 0); lit(1, F_PASS, exp_pass); lit(1, F_SIG, 16'h00AB);
        tick();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; rsp_valid[i] = 1'b0; rsp_in[i] = '0; golden[i] = '0;
            for (int f = 0; f < NF; f++) begin
                lit_en[i][f] = 1'b0; lit_val[i][f] = '0;
            end
        end
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            lit(i, F_BUSY, 0); lit(i, F_PV, 0); lit(i, F_PAT, 0); lit(i, F_SIG, 0);
            lit(i, F_DONE, 0); lit(i, F_PASS, 0); lit(i, F_ERR, 0);
        end
        rst = 1'b0;
        tick();

        run_basic(16'h00AB, 1'b1);
        run_basic(16'h00AC, 1'b0);

        // Stall: five cycles with no response, pattern and signature must hold
        golden[1] = 16'h00AB;
        start[1]  = 1'b1;
        tick();
        start[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            lit(1, F_PAT, 36'h1); lit(1, F_SIG, 0); lit(1, F_PV, 1);
            tick();
        end
        lit(1, F_PAT, 36'h1);
        rsp_valid[1] = 1'b1; rsp_in[1] = 7'h55;
        tick();
        lit(1, F_PAT, 36'h2); lit(1, F_SIG, 16'h0055);
        rsp_in[1] = 7'h01;
        tick();
        rsp_valid[1] = 1'b0;
        finish_run(1);

        // Back-to-back on NUM_PAT=4, response valid already high while idle
        golden[2]    = 16'h0022;
        rsp_valid[2] = 1'b1;
        rsp_in[2]    = 7'h7F;
        tick();
        start[2] = 1'b1;
        tick();
        lit(2, F_PAT, 36'h1); lit(2, F_SIG, 0);
        start[2] = 1'b0; rsp_in[2] = 7'h11;
        tick();
        lit(2, F_PAT, 36'h2);
        start[2] = 1'b1; rsp_in[2] = 7'h22;
        tick();
        lit(2, F_PAT, 36'h4);
        start[2] = 1'b0; rsp_in[2] = 7'h33;
        tick();
        lit(2, F_PAT, 36'h8);
        rsp_in[2] = 7'h44;
        tick();
        lit(2, F_PV, 0); lit(2, F_BUSY, 1); lit(2, F_SIG, 16'h0022);
        tick();
        lit(2, F_DONE, 1); lit(2, F_PASS, 1);
        tick();
        lit(2, F_BUSY, 0); lit(2, F_DONE, 0);
        rsp_valid[2] = 1'b0;
        tick();

        // Reset in the middle of a run after three accepted patterns
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0; rsp_valid[2] = 1'b1; rsp_in[2] = 7'h3C;
        tick();
        tick();
        tick();
        lit(2, F_PAT, 36'h8); lit(2, F_BUSY, 1);
        rst = 1'b1;
        tick();
        lit(2, F_BUSY, 0); lit(2, F_PV, 0); lit(2, F_SIG, 0); lit(2, F_PAT, 0);
        rst = 1'b0; rsp_valid[2] = 1'b0;
        tick();

        // Single-pattern run
        golden[0] = 16'h0055;
        start[0]  = 1'b1;
        tick();
        lit(0, F_PAT, 36'h1); lit(0, F_PV, 1);
        start[0] = 1'b0; rsp_valid[0] = 1'b1; rsp_in[0] = 7'h55;
        tick();
        lit(0, F_PV, 0); lit(0, F_SIG, 16'h0055);
        rsp_valid[0] = 1'b0;
        tick();
        lit(0, F_DONE, 1); lit(0, F_PASS, 1);
        tick();
        lit(0, F_BUSY, 0);
        tick();

`ifdef BIST_TIMEOUT_EN
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int k = 0; k < 15; k++) begin
            lit(0, F_PV, 1); lit(0, F_DONE, 0);
            tick();
        end
        lit(0, F_DONE, 1); lit(0, F_ERR, 1); lit(0, F_PASS, 0); lit(0, F_BUSY, 1);
        tick();
        lit(0, F_BUSY, 0); lit(0, F_ERR, 1);
        start[0] = 1'b1;
        tick();
        lit(0, F_ERR, 0); lit(0, F_PV, 1);
        start[0] = 1'b0; rsp_valid[0] = 1'b1; rsp_in[0] = 7'h00;
        tick();
        rsp_valid[0] = 1'b0;
        finish_run(0);
`endif

        tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
